mult_seq_32bit: RTL and testbench
=================================

Name: mult_seq_32bit

Overview:
- Multi-cycle unsigned 32x32 shift-add multiplier producing a 64-bit product.
- Sits beside the 32-bit carry-lookahead adder in the ALU datapath and feeds it one add per cycle: upper product half plus multiplicand.
- The ALU result mux consumes the product on the done pulse.
- Start/done handshake; fixed latency independent of operand values.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH. Only 32 is verified.
- CNT_W, 5: iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- mcand  input  32  multiplicand; captured on accepted start
- mplier  input  32  multiplier; captured on accepted start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; product is valid
- product  output  64  product register; holds its value until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, busy=0, done=0, product=0, mcand_r=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - With start=1 at an edge: mcand_r<=mcand, product<={32'b0, mplier}, cnt<=0, go to RUN.
  - With start=0: hold all registers.
- RUN, each edge:
  - {c, sum} = product[63:32] + (product[0] ? mcand_r : 0), 33-bit.
  - product <= {c, sum, product[31:1]}. The carry out is never dropped.
  - cnt <= cnt+1.
  - At the edge where cnt==31: go to DONE (exactly 32 RUN edges).
- DONE: done=1 for this single cycle; next edge goes to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+32. A new start can be accepted at edge E0+34 at the earliest.
- busy = (state != IDLE), decoded from state registers, no glitch paths.
- done = (state == DONE).
- start while busy (RUN or DONE) is ignored; mcand and mplier are not recaptured.
- Input changes on mcand and mplier after acceptance have no effect.
- product is undefined-in-meaning but deterministic during RUN. Consumers sample it only when done=1 or later in IDLE.
- Zero operands still take the full 32 iterations; there is no early termination.
- reset_n low mid-RUN: immediate return to reset values. No done pulse. The partial product is cleared.
- Overflow is impossible: a 64-bit product always holds a 32x32 result.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - the MULT_ITER=32 constant
  - the ALU op code that selects this unit for the result mux
- One natural sub-module: mult_seq_ctrl, containing the FSM, counter, and busy/done decode.
- The top level holds the product and mcand_r registers and the 33-bit add. The add is built from the team's 32-bit lookahead adder with its carry out used as bit 32.

Test Plan:
- Reset, then start with mcand=7, mplier=9 -> busy=1 from the next cycle; done pulses once 33 cycles after acceptance; product=64'd63; busy=0 after.
- mcand=32'hFFFFFFFF, mplier=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001. This exercises the carry-out path on every iteration.
- mcand=32'h80000000, mplier=2 -> product=64'h00000001_00000000. Also mcand=0, mplier=32'h12345678 -> product=0 with the same 33-cycle latency.
- Accept 3x5, then pulse start with 100x100 during RUN and again in DONE -> product=15; exactly one done pulse; no second run.
- Accept 123456x654321, assert reset_n=0 at cycle 10 -> busy=0, done=0, product=0 immediately. After release, 6x7 -> product=42.
- Back-to-back: start held high continuously with operand pairs (2,3) then (4,5) -> done pulses 34 cycles apart; products are 6 then 20.

Source files
------------

// File: rtl/mult_seq_32bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings,
// iteration count, ALU select code and the 32-bit lookahead adder used per step.
package mult_seq_32bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  localparam int MULT_ITER = 32;

  // Result-mux select code that routes this unit's product onto the ALU result.
  localparam logic [3:0] ALU_OP_MUL = 4'b1010;

  // 32-bit carry-lookahead add: 4-bit lookahead groups chained group to group.
  // Returns {carry_out, sum} so the caller never loses the carry.
  function automatic logic [32:0] cla_add32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    int          k;
    g    = a & b;
    p    = a ^ b;
    c[0] = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      k        = blk * 4;
      c[k + 1] = g[k] | (p[k] & c[k]);
      c[k + 2] = g[k + 1] | (p[k + 1] & g[k]) | (p[k + 1] & p[k] & c[k]);
      c[k + 3] = g[k + 2] | (p[k + 2] & g[k + 1]) | (p[k + 2] & p[k + 1] & g[k])
               | (p[k + 2] & p[k + 1] & p[k] & c[k]);
      c[k + 4] = g[k + 3] | (p[k + 3] & g[k + 2]) | (p[k + 3] & p[k + 2] & g[k + 1])
               | (p[k + 3] & p[k + 2] & p[k + 1] & g[k])
               | (p[k + 3] & p[k + 2] & p[k + 1] & p[k] & c[k]);
    end
    return {c[32], p ^ c[31:0]};
  endfunction

endpackage

// File: rtl/mult_seq_32bit_ctrl.sv
// Control FSM for the sequential multiplier: accepts start in IDLE, counts the
// fixed iteration budget in RUN, and produces registered busy/done flags.
module mult_seq_32bit_ctrl
  import mult_seq_32bit_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic run
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_ITER - 1);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;

  // Next-state, counter and operand-load decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers; busy/done are registered from the next state so they are
  // exact copies of the state decode without combinational glitch paths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign run  = (state_q == ST_RUN);

endmodule

// File: rtl/mult_seq_32bit.sv
// Unsigned 32x32 shift-add multiplier, one lookahead add per cycle, 64-bit
// product held until the next accepted start.
module mult_seq_32bit
  import mult_seq_32bit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               load_s;
  logic               run_s;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;

  mult_seq_32bit_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .load    (load_s),
    .run     (run_s)
  );

  // One shift-add step: the adder carry becomes the new top bit of the product.
  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    addend_s  = product_q[0] ? mcand_q : {WIDTH{1'b0}};
    sum_s     = cla_add32(product_q[2*WIDTH-1:WIDTH], addend_s);
    if (load_s) begin
      mcand_d   = mcand;
      product_d = {{WIDTH{1'b0}}, mplier};
    end else if (run_s) begin
      product_d = {sum_s, product_q[WIDTH-1:1]};
    end else begin
      product_d = product_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q   <= {WIDTH{1'b0}};
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Scoreboard bench for mult_seq_32bit: directed operand pairs push expected
// products; a negedge monitor checks product and latency on every done pulse.
module tb_mult_seq_32bit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  typedef struct {
    logic [63:0] prod;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc;
  int   done_cnt;

  mult_seq_32bit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("product", product, e.prod);
        check("latency", 64'(cyc), 64'(e.acc + 32));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    int acc;
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{exp, acc});
    @(negedge clk);
    start  = 1'b0;
    mcand  = 32'hDEAD_BEEF;
    mplier = 32'hCAFE_F00D;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 120; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("done_idle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int acc;
    int dc;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    done_cnt = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    mcand    = 32'd0;
    mplier   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(32'd7, 32'd9, 64'd63, 1'b1);
    wait_drain();
    check("product_hold", product, 64'd63);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    wait_drain();
    issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
    wait_drain();
    issue(32'd0, 32'h1234_5678, 64'd0, 1'b1);
    wait_drain();

    // Starts during RUN and during DONE must be ignored.
    dc = done_cnt;
    issue(32'd3, 32'd5, 64'd15, 1'b1);
    repeat (10) @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd100;
    mplier = 32'd100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("no_restart_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    check("no_restart_busy_late", {63'd0, busy}, 64'd0);
    check("single_done", 64'(done_cnt - dc), 64'd1);
    check("ignored_product", product, 64'd15);
    wait_drain();

    // Reset in the middle of a run clears everything with no done pulse.
    dc = done_cnt;
    issue(32'd123456, 32'd654321, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    issue(32'd6, 32'd7, 64'd42, 1'b1);
    wait_drain();

    // Back-to-back with start held high: second accept 34 edges after the first.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd2;
    mplier = 32'd3;
    @(posedge clk);
    #1;
    acc = cyc;
    sb.push_back('{64'd6, acc});
    sb.push_back('{64'd20, acc + 34});
    @(negedge clk);
    mcand  = 32'd4;
    mplier = 32'd5;
    for (int i = 0; i < 60; i++) begin
      if (cyc >= acc + 34) break;
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    check("product_final", product, 64'd20);
    check("total_done", 64'(done_cnt), 64'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
